// File: rtl/fsm.sv
// Byte-stream frame parser: 0xA5, LEN, LEN data bytes, CHK.
// Consumes one byte per clock and publishes a registered status word
// {state, checksum, good-frame count, error count} on out.
module fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in,
    output logic [18:0] out
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CHK  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    localparam logic [7:0] SYNC = 8'hA5;

    state_t     state, state_n;
    logic [7:0] len, len_n;
    logic [7:0] cnt, cnt_n;
    logic [7:0] sum, sum_n;
    logic [3:0] good, good_n;
    logic [3:0] err, err_n;

    // State register; rst low clears it immediately, without a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Frame datapath registers: length, byte counter, checksum and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len  <= 8'd0;
            cnt  <= 8'd0;
            sum  <= 8'd0;
            good <= 4'd0;
            err  <= 4'd0;
        end else begin
            len  <= len_n;
            cnt  <= cnt_n;
            sum  <= sum_n;
            good <= good_n;
            err  <= err_n;
        end
    end

    // Next-state and datapath update. Everything holds unless the current
    // state says otherwise. Sum only moves in LEN (cleared) and DATA
    // (accumulated), so it stays visible through CHK, DONE and ERR.
    // A 0xA5 inside DATA or CHK is plain data: no mid-frame resync.
    always_comb begin
        state_n = IDLE;
        len_n   = len;
        cnt_n   = cnt;
        sum_n   = sum;
        good_n  = good;
        err_n   = err;
        case (state)
            IDLE: begin
                state_n = (in == SYNC) ? LEN : IDLE;
            end
            LEN: begin
                len_n   = in;
                cnt_n   = 8'd0;
                sum_n   = 8'd0;
                state_n = (in == 8'd0) ? ERR : DATA;
            end
            DATA: begin
                sum_n   = sum + in;
                cnt_n   = cnt + 8'd1;
                state_n = (cnt_n == len) ? CHK : DATA;
            end
            CHK: begin
                if (in == sum) begin
                    state_n = DONE;
                    good_n  = good + 4'd1;
                end else begin
                    state_n = ERR;
                    err_n   = (err == 4'd15) ? err : err + 4'd1;
                end
            end
            DONE, ERR: begin
                state_n = (in == SYNC) ? LEN : IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Status word comes straight from registers; the state field doubles as
    // the debug view of the FSM.
    assign out = {state, sum, good, err};

endmodule

// File: tb/tb_fsm.sv
// Directed bench for the frame parser: one task per scenario, each applying
// bytes and comparing the full status word against hand-computed values.
module tb_fsm;

    logic        clk;
    logic        rst;
    logic [7:0]  in;
    logic [18:0] out;

    int vectors;
    int miscompares;

    fsm dut (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .out (out)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one byte at the falling edge, then settle just after the rising edge.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        in = b;
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges and release it with in parked at 0.
    task automatic pulse_reset();
        @(negedge clk);
        in  = 8'h00;
        rst = 1'b0;
        #2;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        in  = 8'h00;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #2;
        vectors++;
        if (out !== 19'h0) begin
            miscompares++;
            $display("FAIL reset_state: out=%h expected=%h", out, 19'h0);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_good_frame();
        logic [7:0]  b[6];
        logic [18:0] e[6];
        b = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h30, 8'h00};
        e = '{{3'd1, 8'h00, 4'd0, 4'd0}, {3'd2, 8'h00, 4'd0, 4'd0},
              {3'd2, 8'h10, 4'd0, 4'd0}, {3'd3, 8'h30, 4'd0, 4'd0},
              {3'd4, 8'h30, 4'd1, 4'd0}, {3'd0, 8'h30, 4'd1, 4'd0}};
        for (int i = 0; i < 6; i++) begin
            send(b[i]);
            vectors++;
            if (out !== e[i]) begin
                miscompares++;
                $display("FAIL good_frame[%0d]: out=%h expected=%h", i, out, e[i]);
            end
        end
    endtask

    task automatic test_bad_checksum();
        logic [7:0]  b[5];
        logic [18:0] e[5];
        b = '{8'hA5, 8'h01, 8'h07, 8'h08, 8'h00};
        e = '{{3'd1, 8'h30, 4'd1, 4'd0}, {3'd2, 8'h00, 4'd1, 4'd0},
              {3'd3, 8'h07, 4'd1, 4'd0}, {3'd5, 8'h07, 4'd1, 4'd1},
              {3'd0, 8'h07, 4'd1, 4'd1}};
        for (int i = 0; i < 5; i++) begin
            send(b[i]);
            vectors++;
            if (out !== e[i]) begin
                miscompares++;
                $display("FAIL bad_checksum[%0d]: out=%h expected=%h", i, out, e[i]);
            end
        end
    endtask

    task automatic test_zero_length();
        logic [7:0] b[3];
        logic [2:0] st[3];
        logic [7:0] sm[3];
        b  = '{8'hA5, 8'h00, 8'h11};
        st = '{3'd1, 3'd5, 3'd0};
        sm = '{8'h07, 8'h00, 8'h00};
        for (int i = 0; i < 3; i++) begin
            send(b[i]);
            vectors++;
            if (out[18:16] !== st[i] || out[15:8] !== sm[i] || out[7:4] !== 4'd1) begin
                miscompares++;
                $display("FAIL zero_length[%0d]: out=%h expected state=%0d sum=%h good=1",
                         i, out, st[i], sm[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  prev_sum;
        logic [3:0]  g;
        logic [18:0] e;
        pulse_reset();
        prev_sum = 8'h00;
        g        = 4'd0;
        for (int i = 0; i < 16; i++) begin
            send(8'hA5);
            e = {3'd1, prev_sum, g, 4'd0};
            vectors++;
            if (out !== e) begin
                miscompares++;
                $display("FAIL b2b_sync[%0d]: out=%h expected=%h", i, out, e);
            end
            send(8'h01);
            send(8'h05);
            send(8'h05);
            g = g + 4'd1;
            e = {3'd4, 8'h05, g, 4'd0};
            vectors++;
            if (out !== e) begin
                miscompares++;
                $display("FAIL b2b_done[%0d]: out=%h expected=%h", i, out, e);
            end
            prev_sum = 8'h05;
        end
        vectors++;
        if (out[7:4] !== 4'd0) begin
            miscompares++;
            $display("FAIL good_wrap: good=%0d expected=0", out[7:4]);
        end
        send(8'h00);
        vectors++;
        if (out !== {3'd0, 8'h05, 4'd0, 4'd0}) begin
            miscompares++;
            $display("FAIL b2b_idle: out=%h expected=%h", out, {3'd0, 8'h05, 4'd0, 4'd0});
        end
    endtask

    task automatic test_saturation();
        logic [3:0]  ec;
        logic [18:0] e;
        ec = 4'd0;
        for (int i = 0; i < 17; i++) begin
            send(8'hA5);
            send(8'h01);
            send(8'h05);
            send(8'h06);
            if (ec != 4'd15) ec = ec + 4'd1;
            e = {3'd5, 8'h05, 4'd0, ec};
            vectors++;
            if (out !== e) begin
                miscompares++;
                $display("FAIL saturation[%0d]: out=%h expected=%h", i, out, e);
            end
        end
        send(8'h00);
        vectors++;
        if (out !== {3'd0, 8'h05, 4'd0, 4'd15}) begin
            miscompares++;
            $display("FAIL sat_idle: out=%h expected=%h", out, {3'd0, 8'h05, 4'd0, 4'd15});
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0]  b[5];
        logic [18:0] e[5];
        send(8'hA5);
        send(8'h03);
        send(8'h11);
        vectors++;
        if (out !== {3'd2, 8'h11, 4'd0, 4'd15}) begin
            miscompares++;
            $display("FAIL pre_reset: out=%h expected=%h", out, {3'd2, 8'h11, 4'd0, 4'd15});
        end
        #2;
        rst = 1'b0;
        in  = 8'h00;
        #1;
        vectors++;
        if (out !== 19'h0) begin
            miscompares++;
            $display("FAIL async_reset: out=%h expected=%h", out, 19'h0);
        end
        @(negedge clk);
        rst = 1'b1;
        b = '{8'hA5, 8'h01, 8'h09, 8'h09, 8'h00};
        e = '{{3'd1, 8'h00, 4'd0, 4'd0}, {3'd2, 8'h00, 4'd0, 4'd0},
              {3'd3, 8'h09, 4'd0, 4'd0}, {3'd4, 8'h09, 4'd1, 4'd0},
              {3'd0, 8'h09, 4'd1, 4'd0}};
        for (int i = 0; i < 5; i++) begin
            send(b[i]);
            vectors++;
            if (out !== e[i]) begin
                miscompares++;
                $display("FAIL post_reset[%0d]: out=%h expected=%h", i, out, e[i]);
            end
        end
    endtask

    task automatic test_noise();
        logic [7:0] v;
        pulse_reset();
        for (int i = 0; i < 100; i++) begin
            v = 8'($urandom_range(0, 255));
            if (v == 8'hA5) v = 8'h5A;
            send(v);
            vectors++;
            if (out !== 19'h0) begin
                miscompares++;
                $display("FAIL noise[%0d]: in=%h out=%h expected=%h", i, v, out, 19'h0);
            end
        end
    endtask

    task automatic test_no_resync();
        logic [7:0]  b[5];
        logic [18:0] e[5];
        pulse_reset();
        b = '{8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h4A};
        e = '{{3'd1, 8'h00, 4'd0, 4'd0}, {3'd2, 8'h00, 4'd0, 4'd0},
              {3'd2, 8'hA5, 4'd0, 4'd0}, {3'd3, 8'h4A, 4'd0, 4'd0},
              {3'd4, 8'h4A, 4'd1, 4'd0}};
        for (int i = 0; i < 5; i++) begin
            send(b[i]);
            vectors++;
            if (out !== e[i]) begin
                miscompares++;
                $display("FAIL no_resync[%0d]: out=%h expected=%h", i, out, e[i]);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_zero_length();
        test_back_to_back();
        test_saturation();
        test_reset_mid_frame();
        test_noise();
        test_no_resync();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fsm.md
FSM -- requirements
Module: fsm

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  sole clock; every register SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; rst=0 SHALL clear all state immediately, with no clock edge required.
REQ-004 in  input  8  byte-stream input, sampled on each rising clk edge while rst=1.
REQ-005 out  output  19  registered status word: out[18:16]=state code, out[15:8]=checksum accumulator, out[7:4]=good-frame count, out[3:0]=error count.

Function
REQ-006 The block SHALL parse frames of the form 0xA5, LEN, LEN data bytes, CHK, consuming exactly one byte per clock.
REQ-007 State codes SHALL be: IDLE=0, LEN=1, DATA=2, CHK=3, DONE=4, ERR=5; codes 6 and 7 SHALL be unused and SHALL transition to IDLE on the next edge.
REQ-008 IDLE: in==0xA5 SHALL go to LEN; any other byte SHALL stay in IDLE.
REQ-009 LEN: the block SHALL latch in as len (8 bits), clear the sum and the byte counter cnt (8 bits), and go to DATA; if in==0 it SHALL instead go to ERR.
REQ-010 DATA: on each byte, sum SHALL take sum+in mod 256 and cnt SHALL take cnt+1; when the new cnt equals len, the state SHALL go to CHK, otherwise it SHALL stay in DATA.
REQ-011 CHK: in==sum SHALL go to DONE and increment the good-frame count; otherwise the state SHALL go to ERR and increment the error count.
REQ-012 DONE and ERR SHALL last exactly one cycle each; the next state SHALL be LEN if in==0xA5 on that cycle, otherwise IDLE.
REQ-013 The good-frame count SHALL wrap from 15 to 0; the error count SHALL saturate at 15.
REQ-014 Sum SHALL change only in LEN (cleared) and DATA (accumulated); it SHALL hold its value in all other states so that out[15:8] shows the last frame's sum through CHK, DONE and ERR.
REQ-015 A byte 0xA5 received in DATA or CHK SHALL be treated as ordinary data; the block SHALL NOT resynchronise mid-frame.
REQ-016 out SHALL be driven directly from registers, with no combinational path from in to out; every effect SHALL appear on out one cycle after the byte that causes it.
REQ-017 The implementation SHALL be a synthesizable single-clock design with no latches.

Reset
REQ-018 While rst=0, the state SHALL be IDLE, and sum, len, cnt, the good-frame count and the error count SHALL all be 0, so out=19'h0.
REQ-019 Asserting rst mid-frame SHALL abort the frame without incrementing either counter; after release, parsing SHALL restart from IDLE on the first rising edge with rst=1.

Verification
REQ-020 Good frame: bytes A5,02,10,20,30 -> state sequence LEN,DATA,DATA,CHK,DONE; out[15:8]=0x30; out[7:4]=1; out[3:0]=0.
REQ-021 Bad checksum: bytes A5,01,07,08 -> state ERR; out[3:0]=1; out[7:4] unchanged.
REQ-022 Zero length: bytes A5,00 -> state ERR after the second byte, then IDLE when the next byte is not A5.
REQ-023 Back-to-back frames: a DONE cycle receiving byte A5 -> state LEN next, with no IDLE cycle; after 16 good frames out[7:4]=0.
REQ-024 Saturation and reset: 17 bad frames -> out[3:0]=15; driving rst=0 during DATA -> out=0 immediately, without a clock edge.
REQ-025 Noise: 100 non-A5 bytes in IDLE -> out remains 0.
